// File: rtl/quadencoder_index_ctrl.sv
// Index-pulse (Z) sequencer for a quadrature encoder counter.
// Sits between the counter's raw signed position and the host.
// It conditions the asynchronous index input, and it captures the position on an
// accepted index edge while armed. It can optionally re-zero the reported position
// (homing), and it flags an armed search that times out.
// Positions are two's-complement values carried in plain vectors; the offset
// subtraction wraps modulo 2^BITS.
module quadencoder_index_ctrl #(
   parameter int BITS           = 32,
   parameter int INDEX_FILTER   = 3,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [BITS-1:0] i_position_in,
   input  logic            i_index,
   input  logic            i_arm,
   input  logic            i_disarm,
   input  logic            i_zero_on_index,
   input  logic            i_latch_clear,
   output logic [BITS-1:0] o_position_out,
   output logic [BITS-1:0] o_latched,
   output logic            o_latched_valid,
   output logic            o_armed,
   output logic            o_timeout_err
);

   localparam logic [7:0]  FILT_MAX = 8'(INDEX_FILTER);
   localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_idx_meta;
   logic            r_idx_s;
   logic [7:0]      r_filt_cnt;
   logic            r_index_f_d;
   logic [31:0]     r_tmo_cnt;
   logic [BITS-1:0] r_offset;
   logic [BITS-1:0] r_position_out;
   logic [BITS-1:0] r_latched;
   logic            r_latched_valid;
   logic            r_armed;
   logic            r_timeout_err;

   logic            w_index_f;
   logic            w_index_edge;

   // Filtered index level and its rising edge; a level that is already high is never an edge.
   assign w_index_f    = (r_filt_cnt == FILT_MAX);
   assign w_index_edge = w_index_f & ~r_index_f_d;

   // Index conditioning: 2-flop synchronizer plus a saturating run-length filter, active in every state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_idx_meta  <= 1'b0;
         r_idx_s     <= 1'b0;
         r_filt_cnt  <= 8'd0;
         r_index_f_d <= 1'b0;
      end else begin
         r_idx_meta  <= i_index;
         r_idx_s     <= r_idx_meta;
         r_index_f_d <= w_index_f;
         if (r_idx_s) begin
            if (r_filt_cnt != FILT_MAX) begin
               r_filt_cnt <= r_filt_cnt + 8'd1;
            end
         end else begin
            r_filt_cnt <= 8'd0;
         end
      end
   end

   // Search FSM. Priority is disarm > accepted edge > timeout > arm. It also
   // owns the capture registers, the offset and the sticky timeout flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= ST_IDLE;
         r_tmo_cnt       <= 32'd0;
         r_offset        <= '0;
         r_latched       <= '0;
         r_latched_valid <= 1'b0;
         r_armed         <= 1'b0;
         r_timeout_err   <= 1'b0;
      end else begin
         // A capture on this same edge overrides the clear further down.
         if (i_latch_clear) begin
            r_latched_valid <= 1'b0;
         end
         case (r_state)
            ST_ARMED: begin
               if (i_disarm) begin
                  r_state <= ST_IDLE;
                  r_armed <= 1'b0;
               end else if (w_index_edge) begin
                  r_state         <= ST_DONE;
                  r_armed         <= 1'b0;
                  r_latched       <= i_position_in;
                  r_latched_valid <= 1'b1;
                  if (i_zero_on_index) begin
                     r_offset <= i_position_in;
                  end
               end else if (TMO_EN && (r_tmo_cnt == TMO_LAST)) begin
                  r_state       <= ST_IDLE;
                  r_armed       <= 1'b0;
                  r_timeout_err <= 1'b1;
               end else if (i_arm) begin
                  r_tmo_cnt <= 32'd0;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 32'd1;
               end
            end
            // IDLE and DONE both accept a new arm, which allows a re-arm one cycle after capture.
            default: begin
               if (i_arm && !i_disarm) begin
                  r_state       <= ST_ARMED;
                  r_armed       <= 1'b1;
                  r_timeout_err <= 1'b0;
                  r_tmo_cnt     <= 32'd0;
               end else begin
                  r_state <= ST_IDLE;
                  r_armed <= 1'b0;
               end
            end
         endcase
      end
   end

   // Reported position: raw count minus the homing offset, registered, wrapping.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_position_out <= '0;
      end else begin
         r_position_out <= i_position_in - r_offset;
      end
   end

   assign o_position_out  = r_position_out;
   assign o_latched       = r_latched;
   assign o_latched_valid = r_latched_valid;
   assign o_armed         = r_armed;
   assign o_timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_quadencoder_index_ctrl.sv
// Bench for quadencoder_index_ctrl: directed scenarios plus a randomized run
// checked against a sample-history reference model.
module tb_quadencoder_index_ctrl;

   localparam int BITS = 32;
   localparam int FILT = 3;
   localparam int TMO  = 100;
   localparam int HW   = FILT + 8;

   logic            clk = 1'b0;
   logic            i_rst = 1'b1;
   logic [BITS-1:0] i_position_in = '0;
   logic            i_index = 1'b0;
   logic            i_arm = 1'b0;
   logic            i_disarm = 1'b0;
   logic            i_zero_on_index = 1'b0;
   logic            i_latch_clear = 1'b0;
   logic [BITS-1:0] o_position_out;
   logic [BITS-1:0] o_latched;
   logic            o_latched_valid;
   logic            o_armed;
   logic            o_timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: search flag, cycles since (re)arm, index sample history.
   bit              m_search;
   int              m_elapsed;
   logic [HW-1:0]   m_hist;
   logic [BITS-1:0] m_offset, m_latched, m_pos_out;
   bit              m_valid, m_err;

   quadencoder_index_ctrl #(
      .BITS(BITS), .INDEX_FILTER(FILT), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clk(clk), .i_rst(i_rst), .i_position_in(i_position_in), .i_index(i_index),
      .i_arm(i_arm), .i_disarm(i_disarm), .i_zero_on_index(i_zero_on_index),
      .i_latch_clear(i_latch_clear), .o_position_out(o_position_out),
      .o_latched(o_latched), .o_latched_valid(o_latched_valid),
      .o_armed(o_armed), .o_timeout_err(o_timeout_err)
   );

   always #5 clk = ~clk;

   // Reference step for one rising edge. An index edge is accepted when the raw samples
   // taken 3..2+FILT edges ago were all high and the one before those was low.
   task automatic model_step();
      bit edge_ok;
      bit capture;
      logic [BITS-1:0] new_out;
      if (i_rst) begin
         m_search = 0; m_elapsed = 0; m_hist = '0;
         m_offset = '0; m_latched = '0; m_pos_out = '0; m_valid = 0; m_err = 0;
      end else begin
         m_hist = {m_hist[HW-2:0], i_index};
         edge_ok = 1'b1;
         for (int j = 0; j < FILT; j++) if (!m_hist[3+j]) edge_ok = 1'b0;
         if (m_hist[3+FILT]) edge_ok = 1'b0;
         new_out = i_position_in - m_offset;
         capture = 0;
         if (m_search) begin
            if (i_disarm) m_search = 0;
            else if (edge_ok) begin
               capture = 1; m_search = 0; m_latched = i_position_in;
               if (i_zero_on_index) m_offset = i_position_in;
            end else if (m_elapsed + 1 == TMO) begin
               m_search = 0; m_err = 1;
            end else if (i_arm) m_elapsed = 0;
            else m_elapsed++;
         end else if (i_arm && !i_disarm) begin
            m_search = 1; m_elapsed = 0; m_err = 0;
         end
         if (capture) m_valid = 1;
         else if (i_latch_clear) m_valid = 0;
         m_pos_out = new_out;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      i_index = 1'b0; i_zero_on_index = 1'b0;
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic arm_pulse();
      i_arm = 1'b1; tick(); i_arm = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; tick(); tick(); i_rst = 1'b0;
      n_tests++;
      if ({o_position_out, o_latched, o_latched_valid, o_armed, o_timeout_err} !== '0) begin
         n_fail++;
         $display("FAIL reset: got pos=%0h lat=%0h v=%0b a=%0b t=%0b, expected all 0",
                  o_position_out, o_latched, o_latched_valid, o_armed, o_timeout_err);
      end
   endtask

   task automatic test_capture();
      arm_pulse();
      n_tests++;
      if (o_armed !== 1'b1) begin n_fail++; $display("FAIL capture_armed: got %0b expected 1", o_armed); end
      i_position_in = 32'd1000; i_index = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         n_tests++;
         if (o_latched_valid !== (k >= 5) || o_armed !== (k < 5)) begin
            n_fail++;
            $display("FAIL capture_timing edge %0d: got v=%0b a=%0b expected v=%0b a=%0b",
                     k, o_latched_valid, o_armed, k >= 5, k < 5);
         end
      end
      n_tests++;
      if (o_latched !== 32'd1000) begin n_fail++; $display("FAIL capture_value: got %0d expected 1000", o_latched); end
      idle(6);
   endtask

   task automatic test_zero_on_index();
      i_zero_on_index = 1'b1; i_position_in = -32'sd250;
      arm_pulse();
      i_index = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      tick();
      n_tests++;
      if (o_position_out !== 32'd0) begin n_fail++; $display("FAIL zero_out0: got %0h expected 0", o_position_out); end
      i_position_in = -32'sd240; tick();
      n_tests++;
      if (o_position_out !== 32'd10) begin n_fail++; $display("FAIL zero_out10: got %0h expected a", o_position_out); end
      idle(6);
   endtask

   task automatic test_short_pulse();
      i_latch_clear = 1'b1; tick(); i_latch_clear = 1'b0;
      arm_pulse();
      i_index = 1'b1; tick(); tick();
      i_index = 1'b0; for (int k = 0; k < 5; k++) tick();
      n_tests++;
      if (o_armed !== 1'b1 || o_latched_valid !== 1'b0) begin
         n_fail++; $display("FAIL short_pulse: got a=%0b v=%0b expected a=1 v=0", o_armed, o_latched_valid);
      end
      i_position_in = 32'd55; i_index = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      i_index = 1'b0; for (int k = 0; k < 3; k++) tick();
      n_tests++;
      if (o_armed !== 1'b0 || o_latched_valid !== 1'b1 || o_latched !== 32'd55) begin
         n_fail++; $display("FAIL long_pulse: got a=%0b v=%0b lat=%0d expected a=0 v=1 lat=55",
                            o_armed, o_latched_valid, o_latched);
      end
      idle(6);
   endtask

   task automatic test_timeout();
      arm_pulse();
      for (int k = 0; k < 99; k++) tick();
      n_tests++;
      if (o_armed !== 1'b1 || o_timeout_err !== 1'b0) begin
         n_fail++; $display("FAIL timeout_early: got a=%0b t=%0b expected a=1 t=0", o_armed, o_timeout_err);
      end
      tick();
      n_tests++;
      if (o_armed !== 1'b0 || o_timeout_err !== 1'b1) begin
         n_fail++; $display("FAIL timeout_fire: got a=%0b t=%0b expected a=0 t=1", o_armed, o_timeout_err);
      end
      arm_pulse();
      n_tests++;
      if (o_armed !== 1'b1 || o_timeout_err !== 1'b0) begin
         n_fail++; $display("FAIL timeout_rearm: got a=%0b t=%0b expected a=1 t=0", o_armed, o_timeout_err);
      end
      i_disarm = 1'b1; tick(); i_disarm = 1'b0;
      n_tests++;
      if (o_armed !== 1'b0) begin n_fail++; $display("FAIL disarm: got %0b expected 0", o_armed); end
   endtask

   task automatic test_wrap();
      i_zero_on_index = 1'b1; i_position_in = 32'h7FFF_FFF0;
      arm_pulse();
      i_index = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      i_position_in = 32'h8000_0010; tick();
      n_tests++;
      if (o_position_out !== 32'h0000_0020) begin
         n_fail++; $display("FAIL wrap: got %0h expected 20", o_position_out);
      end
      idle(6);
   endtask

   task automatic test_simultaneous();
      // disarm on the accepting edge: no capture
      i_latch_clear = 1'b1; tick(); i_latch_clear = 1'b0;
      arm_pulse();
      i_position_in = 32'd4242; i_index = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      i_disarm = 1'b1; tick(); i_disarm = 1'b0;
      n_tests++;
      if (o_armed !== 1'b0 || o_latched_valid !== 1'b0 || o_latched !== 32'h7FFF_FFF0) begin
         n_fail++; $display("FAIL disarm_vs_edge: got a=%0b v=%0b lat=%0h expected a=0 v=0 lat=7ffffff0",
                            o_armed, o_latched_valid, o_latched);
      end
      idle(6);
      // latch_clear on the capture edge: valid stays set
      arm_pulse();
      i_position_in = 32'd777; i_index = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      i_latch_clear = 1'b1; tick(); i_latch_clear = 1'b0;
      n_tests++;
      if (o_latched_valid !== 1'b1 || o_latched !== 32'd777) begin
         n_fail++; $display("FAIL clear_vs_capture: got v=%0b lat=%0d expected v=1 lat=777", o_latched_valid, o_latched);
      end
      idle(6);
      // reset mid-search
      arm_pulse(); tick(); tick();
      i_rst = 1'b1; tick(); i_rst = 1'b0;
      n_tests++;
      if ({o_position_out, o_latched, o_latched_valid, o_armed, o_timeout_err} !== '0) begin
         n_fail++; $display("FAIL reset_mid_armed: got pos=%0h lat=%0h v=%0b a=%0b t=%0b, expected all 0",
                            o_position_out, o_latched, o_latched_valid, o_armed, o_timeout_err);
      end
   endtask

   task automatic test_random();
      int run_left = 0;
      logic lvl = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (run_left == 0) begin
            lvl = 1'($urandom_range(0, 1));
            run_left = $urandom_range(1, 7);
         end
         run_left--;
         i_index         = lvl;
         i_arm           = ($urandom_range(0, 9) == 0);
         i_disarm        = ($urandom_range(0, 39) == 0);
         i_latch_clear   = ($urandom_range(0, 14) == 0);
         i_zero_on_index = 1'($urandom_range(0, 1));
         i_position_in   = $urandom;
         i_rst           = ($urandom_range(0, 399) == 0);
         tick();
         n_tests++;
         if (o_position_out !== m_pos_out || o_latched !== m_latched || o_latched_valid !== m_valid
             || o_armed !== m_search || o_timeout_err !== m_err) begin
            n_fail++;
            $display("FAIL random cyc %0d: got pos=%0h lat=%0h v=%0b a=%0b t=%0b expected pos=%0h lat=%0h v=%0b a=%0b t=%0b",
                     c, o_position_out, o_latched, o_latched_valid, o_armed, o_timeout_err,
                     m_pos_out, m_latched, m_valid, m_search, m_err);
         end
      end
      i_arm = 1'b0; i_disarm = 1'b0; i_latch_clear = 1'b0; i_rst = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_capture();
      test_zero_on_index();
      test_short_pulse();
      test_timeout();
      test_wrap();
      test_simultaneous();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/quadencoder_index_ctrl.md
Name: quadencoder_index_ctrl

Overview:
- Controller sequencing index-pulse (Z) handling for a quadrature encoder counter; sits between the counter's signed position output and the host interface.
- When armed by the host, waits for a filtered index edge, then latches position and optionally re-zeroes the reported position (homing).
- Provides a timeout on the armed search.

Parameters:
BITS, 32, width of position_in, position_out and latched.
INDEX_FILTER, 3, consecutive synchronized high samples required to accept index; legal range 1..255.
TIMEOUT_CYCLES, 0, armed-search timeout in clk cycles; 0 disables timeout.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-high.
position_in  input  BITS  signed raw count from the quadrature counter, already in clk domain.
index  input  1  asynchronous encoder Z pulse.
arm  input  1  one-cycle pulse: start index search.
disarm  input  1  one-cycle pulse: abort search.
zero_on_index  input  1  level, sampled at capture: 1 loads offset with the captured position.
latch_clear  input  1  one-cycle pulse: clear latched_valid.
position_out  output  BITS  signed, registered: position_in minus offset.
latched  output  BITS  signed raw position_in at last accepted index.
latched_valid  output  1  capture since last clear.
armed  output  1  FSM is in ARMED.
timeout_err  output  1  sticky: last search timed out.

Behaviour:
- Reset (rst high at a clk edge):
  - FSM goes to IDLE; offset = 0; all filter, sync and timeout state cleared.
  - position_out = 0, latched = 0, latched_valid = 0, armed = 0, timeout_err = 0.
  - Reset mid-search aborts the search with no capture.
- Index conditioning:
  - 2-flop synchronizer feeds index_s.
  - filt_cnt increments while index_s = 1 and saturates at INDEX_FILTER; it clears to 0 when index_s = 0.
  - Filtered level index_f is 1 when filt_cnt = INDEX_FILTER.
  - Accepted edge = index_f rising.
  - Latency: if index is first sampled high at edge 0 and held, the capture registers update at edge 2 + INDEX_FILTER.
  - Pulses shorter than INDEX_FILTER samples are ignored.
  - Conditioning runs in every state.
- FSM states: IDLE, ARMED, DONE.
  - IDLE:
    - arm -> ARMED; clears timeout_err; loads tmo_cnt = 0.
  - ARMED (armed = 1):
    - Accepted edge -> DONE: latched <= position_in; latched_valid <= 1; if zero_on_index, offset <= position_in.
    - disarm -> IDLE, no capture.
    - TIMEOUT_CYCLES != 0 and tmo_cnt reaches TIMEOUT_CYCLES - 1 with no edge -> IDLE, timeout_err <= 1.
    - Otherwise tmo_cnt increments.
  - DONE:
    - Next cycle -> IDLE unconditionally.
    - arm in DONE is treated as in IDLE (re-arm allowed one cycle after capture).
- Priority at one edge: rst > disarm > accepted edge > timeout > arm.
  - arm in ARMED with none of the above restarts tmo_cnt to 0.
  - An index edge already high when arm arrives is not an edge; a new rising index_f is required.
- Output arithmetic:
  - position_out <= position_in - offset every cycle: 1-cycle latency, modulo 2^BITS two's-complement wrap, no saturation.
  - The offset change takes effect in the subtraction from the cycle after capture.
- latch_clear: latched_valid <= 0; latched keeps its value. A capture on the same edge wins, so latched_valid = 1.
- Edges outside ARMED never change latched, offset or latched_valid.

Test Plan:
- Reset, arm, hold position_in = 1000, raise index for 10 cycles (INDEX_FILTER = 3) -> latched = 1000 and latched_valid = 1 exactly 5 edges after index first sampled; armed drops the same edge.
- Same flow with zero_on_index = 1 and position_in = -250 -> offset = -250; next cycle position_out = 0; position_in = -240 -> position_out = 10.
- Index pulse 2 samples wide while armed -> no capture, armed stays 1; then a 4-sample pulse -> capture.
- TIMEOUT_CYCLES = 100, arm, no index -> timeout_err = 1 and armed = 0 after 100 cycles; next arm clears timeout_err.
- Wrap-around: offset = 0x7FFFFFF0 via capture, position_in = 0x80000010 -> position_out = 0x00000020.
- Simultaneous cases:
  - disarm on the edge an accepted index arrives -> no capture.
  - latch_clear on a capture edge -> latched_valid = 1.
  - rst mid-ARMED -> all outputs 0.
